// File: rtl/keypad_scanner.sv
// keypad_scanner: column-strobed matrix keypad scanner with
// whole-frame debounce and registered press/release events.
module keypad_scanner #(
    parameter int NUM_ROWS        = 4,
    parameter int NUM_COLS        = 4,
    parameter int COL_CYCLES      = 100000,
    parameter int SAMPLE_AT       = 8,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int HEX_MAP         = 1,
    localparam int NK = NUM_ROWS * NUM_COLS,
    localparam int IW = $clog2(NK),
    localparam int CW = (IW > 4) ? IW : 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    output logic [IW-1:0]       key_index,
    output logic [CW-1:0]       key_code,
    output logic                key_held,
    output logic                key_press,
    output logic                key_release,
    output logic                multi_key
);
    localparam int SW = $clog2(COL_CYCLES);
    localparam int PW = $clog2(NUM_COLS);

    typedef enum logic [1:0] {
        CL_NONE,
        CL_KEY,
        CL_MULTI
    } cls_e;

    logic [SW-1:0]       slot, slot_nxt;
    logic [PW-1:0]       ptr, ptr_nxt;
    logic                running;
    logic                slot_end, frame_end, sample;
    logic [NUM_ROWS-1:0] row_m, row_s;
    logic [NK-1:0]       pressed, hits;
    cls_e                cls_kind, prev_kind, acc_kind, acc_nxt;
    logic [IW-1:0]       cls_idx, prev_idx;
    logic [3:0]          dcnt, dcnt_nxt;
    logic                same, accept;
    logic [IW-1:0]       idx_n;
    logic [CW-1:0]       code_n;
    logic                held_n, press_n, rel_n, multi_n;

    function automatic logic [CW-1:0] hex_map(input logic [IW-1:0] k);
        logic [3:0] h;
        h = 4'h0;
        case (int'(k))
            0:  h = 4'h1;
            1:  h = 4'h2;
            2:  h = 4'h3;
            3:  h = 4'hA;
            4:  h = 4'h4;
            5:  h = 4'h5;
            6:  h = 4'h6;
            7:  h = 4'hB;
            8:  h = 4'h7;
            9:  h = 4'h8;
            10: h = 4'h9;
            11: h = 4'hC;
            12: h = 4'h0;
            13: h = 4'hF;
            14: h = 4'hE;
            15: h = 4'hD;
            default: h = 4'h0;
        endcase
        if (HEX_MAP == 1 && NUM_ROWS == 4 && NUM_COLS == 4)
            return CW'(h);
        return CW'(k);
    endfunction

    // running holds the scan still for the first cycle so col[0] gets a full slot
    assign slot_end  = running && (slot == SW'(COL_CYCLES - 1));
    assign frame_end = slot_end && (ptr == PW'(NUM_COLS - 1));
    assign sample    = running && (slot == SW'(SAMPLE_AT));

    always_comb begin
        slot_nxt = slot;
        ptr_nxt  = ptr;
        if (slot_end) begin
            slot_nxt = '0;
            ptr_nxt  = (ptr == PW'(NUM_COLS - 1)) ? '0 : ptr + PW'(1);
        end else if (running) begin
            slot_nxt = slot + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            slot    <= '0;
            ptr     <= '0;
            col     <= '1;
            row_m   <= '1;
            row_s   <= '1;
        end else begin
            running <= 1'b1;
            slot    <= slot_nxt;
            ptr     <= ptr_nxt;
            col     <= ~(NUM_COLS'(1) << ptr_nxt);
            row_m   <= row;
            row_s   <= row_m;
        end
    end

    always_comb begin
        hits = '0;
        for (int r = 0; r < NUM_ROWS; r++)
            for (int c = 0; c < NUM_COLS; c++)
                if (PW'(c) == ptr && !row_s[r])
                    hits[r*NUM_COLS+c] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pressed <= '0;
        else if (frame_end)
            pressed <= '0;
        else if (sample)
            pressed <= pressed | hits;
    end

    always_comb begin
        logic one, many;
        one     = 1'b0;
        many    = 1'b0;
        cls_idx = '0;
        for (int k = 0; k < NK; k++) begin
            if (pressed[k]) begin
                if (one)
                    many = 1'b1;
                one     = 1'b1;
                cls_idx = IW'(k);
            end
        end
        cls_kind = many ? CL_MULTI : (one ? CL_KEY : CL_NONE);
    end

    assign same = (cls_kind == prev_kind) &&
                  (cls_kind != CL_KEY || cls_idx == prev_idx);
    assign dcnt_nxt = !same ? 4'd1 :
                      (dcnt == 4'd15) ? 4'd15 : dcnt + 4'd1;
    assign accept = frame_end &&
                    (dcnt_nxt >= 4'(DEBOUNCE_FRAMES)) &&
                    !((cls_kind == acc_kind) &&
                      (cls_kind != CL_KEY || cls_idx == key_index));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_kind <= CL_NONE;
            prev_idx  <= '0;
            dcnt      <= '0;
        end else if (frame_end) begin
            prev_kind <= cls_kind;
            prev_idx  <= cls_idx;
            dcnt      <= dcnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_kind <= CL_NONE;
        else
            acc_kind <= acc_nxt;
    end

    always_comb begin
        acc_nxt = acc_kind;
        if (accept)
            acc_nxt = cls_kind;
    end

    // a multi-key frame never releases the held key on its own
    always_comb begin
        idx_n   = key_index;
        code_n  = key_code;
        held_n  = key_held;
        multi_n = multi_key;
        press_n = 1'b0;
        rel_n   = 1'b0;
        if (accept) begin
            unique case (1'b1)
                (cls_kind == CL_NONE): begin
                    multi_n = 1'b0;
                    rel_n   = key_held;
                    held_n  = 1'b0;
                end
                (cls_kind == CL_KEY): begin
                    multi_n = 1'b0;
                    if (!key_held || key_index != cls_idx) begin
                        press_n = 1'b1;
                        rel_n   = key_held;
                        idx_n   = cls_idx;
                        code_n  = hex_map(cls_idx);
                        held_n  = 1'b1;
                    end
                end
                (cls_kind == CL_MULTI): multi_n = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_index   <= '0;
            key_code    <= '0;
            key_held    <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            multi_key   <= 1'b0;
        end else begin
            key_index   <= idx_n;
            key_code    <= code_n;
            key_held    <= held_n;
            key_press   <= press_n;
            key_release <= rel_n;
            multi_key   <= multi_n;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench for keypad_scanner,
// ideal 4x4 keypad model driven by the scanned columns.
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row, col, key_index, key_code;
    logic        key_held, key_press, key_release, multi_key;
    logic [15:0] keys = '0;
    int          cyc;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic       press;
        logic       rel;
        logic [3:0] idx;
        logic [3:0] code;
        logic       held;
        logic       multi;
        int         at;
    } ev_t;
    ev_t exp_q[$];

    always #5 clk = ~clk;

    keypad_scanner #(
        .NUM_ROWS(4), .NUM_COLS(4), .COL_CYCLES(16),
        .SAMPLE_AT(8), .DEBOUNCE_FRAMES(3), .HEX_MAP(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .col(col),
        .key_index(key_index), .key_code(key_code),
        .key_held(key_held), .key_press(key_press),
        .key_release(key_release), .multi_key(multi_key)
    );

    always_comb begin
        row = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c])
                    row[r] = 1'b0;
    end

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (key_press || key_release)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {key_press, key_release}, 0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("ev_press", key_press, e.press);
                chk("ev_release", key_release, e.rel);
                chk("ev_index", key_index, e.idx);
                chk("ev_code", key_code, e.code);
                chk("ev_held", key_held, e.held);
                chk("ev_multi", multi_key, e.multi);
                chk("ev_cycle", cyc, e.at);
            end
        end
    end

    task automatic chk_col();
        logic [3:0] e;
        e = '1;
        e[((cyc - 1) / 16) % 4] = 1'b0;
        chk("col_scan", col, e);
    endtask

    task automatic frame_start();
        int n = 0;
        while ((cyc % 64) != 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("frame_align_timeout", n, 0);
    endtask

    task automatic step(input logic [15:0] k, input bit ev,
                        input logic p, input logic r,
                        input logic [3:0] idx, input logic [3:0] code,
                        input logic h, input logic m, input int nfr);
        frame_start();
        keys = k;
        if (ev) exp_q.push_back('{p, r, idx, code, h, m, cyc + 3 * 64});
        repeat (nfr * 64) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_col", col, 4'b1111);
        chk("rst_index", key_index, 0);
        chk("rst_code", key_code, 0);
        chk("rst_held", key_held, 0);
        chk("rst_press", key_press, 0);
        chk("rst_release", key_release, 0);
        chk("rst_multi", multi_key, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            chk_col();
        end

        step(16'h0040, 1, 1, 0, 4'd6, 4'h6, 1, 0, 5);
        chk("held_after_press", key_held, 1);
        chk("index_after_press", key_index, 6);
        chk("code_after_press", key_code, 4'h6);

        step(16'h0000, 1, 0, 1, 4'd6, 4'h6, 0, 0, 4);
        chk("held_after_release", key_held, 0);
        chk("code_kept", key_code, 4'h6);

        for (int i = 0; i < 6; i++)
            step((i % 2 == 0) ? 16'h0008 : 16'h0000,
                 0, 0, 0, 0, 0, 0, 0, 1);
        step(16'h0000, 0, 0, 0, 0, 0, 0, 0, 3);
        chk("held_after_bounce", key_held, 0);

        step(16'h0021, 0, 0, 0, 0, 0, 0, 0, 4);
        chk("multi_set", multi_key, 1);
        chk("multi_no_hold", key_held, 0);

        step(16'h0001, 1, 1, 0, 4'd0, 4'h1, 1, 0, 4);
        chk("multi_cleared", multi_key, 0);
        chk("code_key0", key_code, 4'h1);

        step(16'h8000, 1, 1, 1, 4'd15, 4'hD, 1, 0, 4);
        chk("index_key15", key_index, 15);

        step(16'h8001, 0, 0, 0, 0, 0, 0, 0, 4);
        chk("multi_held_multi", multi_key, 1);
        chk("multi_held_held", key_held, 1);
        chk("multi_held_index", key_index, 15);

        step(16'h0000, 1, 0, 1, 4'd15, 4'hD, 0, 0, 4);
        chk("multi_none_multi", multi_key, 0);

        step(16'h0040, 1, 1, 0, 4'd6, 4'h6, 1, 0, 4);
        repeat (21) @(negedge clk);
        rst_n = 1'b0;
        keys  = '0;
        #1;
        chk("mid_rst_col", col, 4'b1111);
        chk("mid_rst_index", key_index, 0);
        chk("mid_rst_code", key_code, 0);
        chk("mid_rst_held", key_held, 0);
        chk("mid_rst_press", key_press, 0);
        chk("mid_rst_release", key_release, 0);
        chk("mid_rst_multi", multi_key, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk_col();
        end
        repeat (128) @(negedge clk);
        chk("events_pending", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
